// File: rtl/run_method_caller.sv
// Initiator-side sequencer for run_req/run_busy method blocks: buffers operands,
// issues one callee call per operand, and returns the result (or a timeout) downstream.
module run_method_caller #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     ce,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic [WIDTH-1:0]         i_cmd_data,
    output logic                     o_run_req,
    output logic [WIDTH-1:0]         o_run_input_a_0,
    input  logic                     i_run_busy,
    input  logic [WIDTH-1:0]         i_run_result,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [WIDTH-1:0]         o_rsp_data,
    output logic                     o_rsp_timeout,
    output logic [$clog2(DEPTH):0]   o_fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_s;

    logic [WIDTH-1:0]   mem_r [DEPTH];
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [CW-1:0]      count_r;

    logic [TW-1:0]      timer_r;
    logic [TW-1:0]      timer_s;
    logic               run_req_r;
    logic               run_req_s;
    logic [WIDTH-1:0]   run_input_r;
    logic [WIDTH-1:0]   run_input_s;
    logic               rsp_valid_r;
    logic               rsp_valid_s;
    logic [WIDTH-1:0]   rsp_data_r;
    logic [WIDTH-1:0]   rsp_data_s;
    logic               rsp_timeout_r;
    logic               rsp_timeout_s;

    logic               full_s;
    logic               empty_s;
    logic               push_s;
    logic               pop_s;
    logic               rsp_accept_s;
    logic [WIDTH-1:0]   head_s;

    assign full_s       = (count_r == CW'(DEPTH));
    assign empty_s      = (count_r == {CW{1'b0}});
    assign push_s       = i_cmd_valid & ~full_s;
    assign rsp_accept_s = rsp_valid_r & i_rsp_ready;
    assign head_s       = mem_r[rd_ptr_r];

    // Sequencer next-state: IDLE waits for an operand and a free response slot,
    // so a new call never starts while a response is still unconsumed.
    always_comb begin
        state_s       = state_r;
        timer_s       = timer_r;
        run_req_s     = run_req_r;
        run_input_s   = run_input_r;
        rsp_data_s    = rsp_data_r;
        rsp_timeout_s = rsp_timeout_r;
        pop_s         = 1'b0;
        if (rsp_accept_s) begin
            rsp_valid_s = 1'b0;
        end else begin
            rsp_valid_s = rsp_valid_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (!empty_s && !rsp_valid_r) begin
                    pop_s       = 1'b1;
                    run_input_s = head_s;
                    run_req_s   = 1'b1;
                    state_s     = ST_REQ;
                end else begin
                    state_s     = ST_IDLE;
                end
            end
            ST_REQ: begin
                run_req_s = 1'b0;
                timer_s   = {TW{1'b0}};
                state_s   = ST_ACK;
            end
            ST_ACK: begin
                if (i_run_busy) begin
                    state_s = ST_RUN;
                end else if (timer_r == TW'(ACK_TIMEOUT - 1)) begin
                    rsp_valid_s   = 1'b1;
                    rsp_timeout_s = 1'b1;
                    rsp_data_s    = {WIDTH{1'b0}};
                    state_s       = ST_IDLE;
                end else begin
                    timer_s = timer_r + TW'(1);
                end
            end
            ST_RUN: begin
                // Result is only valid on the busy falling edge; no timeout while running.
                if (!i_run_busy) begin
                    rsp_data_s    = i_run_result;
                    rsp_timeout_s = 1'b0;
                    rsp_valid_s   = 1'b1;
                    state_s       = ST_IDLE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                run_req_s = 1'b0;
                state_s   = ST_IDLE;
            end
        endcase
    end

    // FSM state and registered outputs; everything holds while ce is low.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            timer_r       <= {TW{1'b0}};
            run_req_r     <= 1'b0;
            run_input_r   <= {WIDTH{1'b0}};
            rsp_valid_r   <= 1'b0;
            rsp_data_r    <= {WIDTH{1'b0}};
            rsp_timeout_r <= 1'b0;
        end else if (ce) begin
            state_r       <= state_s;
            timer_r       <= timer_s;
            run_req_r     <= run_req_s;
            run_input_r   <= run_input_s;
            rsp_valid_r   <= rsp_valid_s;
            rsp_data_r    <= rsp_data_s;
            rsp_timeout_r <= rsp_timeout_s;
        end
    end

    // Operand storage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (ce && push_s) begin
            mem_r[wr_ptr_r] <= i_cmd_data;
        end
    end

    // Operand pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (ce) begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign o_cmd_ready     = ~full_s;
    assign o_run_req       = run_req_r;
    assign o_run_input_a_0 = run_input_r;
    assign o_rsp_valid     = rsp_valid_r;
    assign o_rsp_data      = rsp_data_r;
    assign o_rsp_timeout   = rsp_timeout_r;
    assign o_fifo_count    = count_r;

endmodule

// File: tb/tb_run_method_caller.sv
// Directed bench for run_method_caller with a simple callee model that raises busy
// one cycle after req for seven cycles and returns operand + 0x00933333.
module tb_run_method_caller;

    localparam logic [31:0] RES_OFFSET = 32'h0093_3333;
    localparam int          BUSY_LEN   = 7;

    logic        clock;
    logic        reset_n;
    logic        ce;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [31:0] i_cmd_data;
    logic        o_run_req;
    logic [31:0] o_run_input_a_0;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_data;
    logic        o_rsp_timeout;
    logic [2:0]  o_fifo_count;

    logic        busy_m;
    logic [31:0] result_m;
    int          busy_cnt;
    logic        callee_en;

    int          n_checks;
    int          n_fail;

    logic [31:0] issued [16];
    logic [31:0] rsp_seen [16];
    logic        rsp_to [16];
    int          n_iss;
    int          n_rsp;
    logic        rsp_taken;

    run_method_caller #(.WIDTH(32), .DEPTH(4), .ACK_TIMEOUT(15)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .ce              (ce),
        .i_cmd_valid     (i_cmd_valid),
        .o_cmd_ready     (o_cmd_ready),
        .i_cmd_data      (i_cmd_data),
        .o_run_req       (o_run_req),
        .o_run_input_a_0 (o_run_input_a_0),
        .i_run_busy      (busy_m),
        .i_run_result    (result_m),
        .o_rsp_valid     (o_rsp_valid),
        .i_rsp_ready     (i_rsp_ready),
        .o_rsp_data      (o_rsp_data),
        .o_rsp_timeout   (o_rsp_timeout),
        .o_fifo_count    (o_fifo_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Callee model: independent of ce, reset together with the caller.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_m   <= 1'b0;
            busy_cnt <= 0;
            result_m <= 32'h0;
        end else if (busy_m) begin
            if (busy_cnt <= 1) busy_m <= 1'b0;
            else busy_cnt <= busy_cnt - 1;
        end else if (o_run_req && callee_en) begin
            busy_m   <= 1'b1;
            busy_cnt <= BUSY_LEN;
            result_m <= o_run_input_a_0 + RES_OFFSET;
        end
    end

    task automatic observe();
        if (o_run_req && n_iss < 16) begin
            issued[n_iss] = o_run_input_a_0;
            n_iss++;
        end
        if (o_rsp_valid && !rsp_taken) begin
            if (n_rsp < 16) begin
                rsp_seen[n_rsp] = o_rsp_data;
                rsp_to[n_rsp]   = o_rsp_timeout;
                n_rsp++;
            end
            rsp_taken = 1'b1;
        end else if (!o_rsp_valid) begin
            rsp_taken = 1'b0;
        end
    endtask

    task automatic clear_trackers();
        n_iss = 0;
        n_rsp = 0;
        rsp_taken = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        n_checks++; if (o_run_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b exp 0", o_run_req); end
        n_checks++; if (o_run_input_a_0 !== 32'h0) begin n_fail++; $display("FAIL reset_input: got %h exp 0", o_run_input_a_0); end
        n_checks++; if (o_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", o_rsp_valid); end
        n_checks++; if (o_rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h exp 0", o_rsp_data); end
        n_checks++; if (o_rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b exp 0", o_rsp_timeout); end
        n_checks++; if (o_fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", o_fifo_count); end
        reset_n = 1'b1;
        @(negedge clock);
        n_checks++; if (o_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b exp 1", o_cmd_ready); end
    endtask

    task automatic test_single_call();
        int cyc;
        int reqs;
        @(negedge clock);
        i_cmd_valid = 1'b1; i_cmd_data = 32'h3F80_0000;
        @(negedge clock);
        i_cmd_valid = 1'b0;
        n_checks++; if (o_fifo_count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d exp 1", o_fifo_count); end
        n_checks++; if (o_run_req !== 1'b0) begin n_fail++; $display("FAIL single_req_early: got %b exp 0", o_run_req); end
        @(negedge clock);
        n_checks++; if (o_run_req !== 1'b1) begin n_fail++; $display("FAIL single_req: got %b exp 1", o_run_req); end
        n_checks++; if (o_run_input_a_0 !== 32'h3F80_0000) begin n_fail++; $display("FAIL single_input: got %h exp 3f800000", o_run_input_a_0); end
        cyc = 0; reqs = 0;
        while (!o_rsp_valid && cyc < 40) begin
            @(negedge clock); cyc++;
            if (o_run_req) reqs++;
        end
        n_checks++; if (cyc !== 9) begin n_fail++; $display("FAIL single_latency: got %0d exp 9", cyc); end
        n_checks++; if (reqs !== 0) begin n_fail++; $display("FAIL single_req_pulse: extra reqs %0d exp 0", reqs); end
        n_checks++; if (o_rsp_data !== 32'h4013_3333) begin n_fail++; $display("FAIL single_data: got %h exp 40133333", o_rsp_data); end
        n_checks++; if (o_rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL single_timeout: got %b exp 0", o_rsp_timeout); end
        @(negedge clock);
        n_checks++; if (o_rsp_valid !== 1'b1 || o_rsp_data !== 32'h4013_3333) begin n_fail++; $display("FAIL single_hold: valid %b data %h exp 1/40133333", o_rsp_valid, o_rsp_data); end
        i_rsp_ready = 1'b1;
        @(negedge clock);
        i_rsp_ready = 1'b0;
        n_checks++; if (o_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_accept: got %b exp 0", o_rsp_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ops [6];
        int   i;
        int   guard;
        logic rdy;
        logic push_now;
        ops[0] = 32'h1111_0001; ops[1] = 32'h2222_0002; ops[2] = 32'h3333_0003;
        ops[3] = 32'h4444_0004; ops[4] = 32'h5555_0005; ops[5] = 32'h6666_0006;
        clear_trackers();
        i_rsp_ready = 1'b0;
        i = 0; guard = 0;
        @(negedge clock);
        while (i < 5 && guard < 40) begin
            i_cmd_valid = 1'b1; i_cmd_data = ops[i]; rdy = o_cmd_ready;
            @(negedge clock); guard++; observe();
            if (rdy) i++;
        end
        i_cmd_valid = 1'b1; i_cmd_data = ops[5];
        n_checks++; if (o_fifo_count !== 3'd4) begin n_fail++; $display("FAIL b2b_full_count: got %0d exp 4", o_fifo_count); end
        n_checks++; if (o_cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready: got %b exp 0", o_cmd_ready); end
        repeat (12) begin
            @(negedge clock); observe();
        end
        n_checks++; if (o_rsp_valid !== 1'b1 || o_fifo_count !== 3'd4 || n_iss !== 1) begin n_fail++; $display("FAIL b2b_stall: valid %b count %0d issued %0d exp 1/4/1", o_rsp_valid, o_fifo_count, n_iss); end
        i_rsp_ready = 1'b1;
        guard = 0;
        while (n_rsp < 6 && guard < 300) begin
            push_now = i_cmd_valid && o_cmd_ready;
            @(negedge clock); guard++; observe();
            if (push_now) i_cmd_valid = 1'b0;
        end
        @(negedge clock);
        i_rsp_ready = 1'b0;
        n_checks++; if (n_iss !== 6 || n_rsp !== 6) begin n_fail++; $display("FAIL b2b_counts: issued %0d responses %0d exp 6/6", n_iss, n_rsp); end
        for (int k = 0; k < 6; k++) begin
            n_checks++; if (issued[k] !== ops[k]) begin n_fail++; $display("FAIL b2b_issue[%0d]: got %h exp %h", k, issued[k], ops[k]); end
            n_checks++; if (rsp_seen[k] !== ops[k] + RES_OFFSET || rsp_to[k] !== 1'b0) begin n_fail++; $display("FAIL b2b_rsp[%0d]: got %h/%b exp %h/0", k, rsp_seen[k], rsp_to[k], ops[k] + RES_OFFSET); end
        end
        n_checks++; if (o_fifo_count !== 3'd0 || o_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: count %0d valid %b exp 0/0", o_fifo_count, o_rsp_valid); end
    endtask

    task automatic test_timeout();
        int cyc;
        callee_en = 1'b0;
        @(negedge clock);
        i_cmd_valid = 1'b1; i_cmd_data = 32'h1234_5678;
        @(negedge clock);
        i_cmd_data = 32'hCAFE_0001;
        @(negedge clock);
        i_cmd_valid = 1'b0;
        n_checks++; if (o_run_req !== 1'b1 || o_run_input_a_0 !== 32'h1234_5678) begin n_fail++; $display("FAIL to_req: req %b input %h exp 1/12345678", o_run_req, o_run_input_a_0); end
        n_checks++; if (o_fifo_count !== 3'd1) begin n_fail++; $display("FAIL to_pushpop_count: got %0d exp 1", o_fifo_count); end
        cyc = 0;
        while (!o_rsp_valid && cyc < 40) begin
            @(negedge clock); cyc++;
        end
        // one cycle REQ plus fifteen in ACK
        n_checks++; if (cyc !== 16) begin n_fail++; $display("FAIL to_latency: got %0d exp 16", cyc); end
        n_checks++; if (o_rsp_timeout !== 1'b1 || o_rsp_data !== 32'h0) begin n_fail++; $display("FAIL to_flag: timeout %b data %h exp 1/0", o_rsp_timeout, o_rsp_data); end
        callee_en = 1'b1;
        @(negedge clock);
        n_checks++; if (o_rsp_valid !== 1'b1 || o_run_req !== 1'b0 || o_fifo_count !== 3'd1) begin n_fail++; $display("FAIL to_hold: valid %b req %b count %0d exp 1/0/1", o_rsp_valid, o_run_req, o_fifo_count); end
        i_rsp_ready = 1'b1;
        @(negedge clock);
        i_rsp_ready = 1'b0;
        n_checks++; if (o_rsp_valid !== 1'b0 || o_run_req !== 1'b0) begin n_fail++; $display("FAIL to_bubble: valid %b req %b exp 0/0", o_rsp_valid, o_run_req); end
        @(negedge clock);
        n_checks++; if (o_run_req !== 1'b1 || o_run_input_a_0 !== 32'hCAFE_0001) begin n_fail++; $display("FAIL to_next_req: req %b input %h exp 1/cafe0001", o_run_req, o_run_input_a_0); end
        cyc = 0;
        while (!o_rsp_valid && cyc < 40) begin
            @(negedge clock); cyc++;
        end
        n_checks++; if (cyc !== 9 || o_rsp_data !== 32'hCAFE_0001 + RES_OFFSET || o_rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL to_next_rsp: lat %0d data %h to %b exp 9/%h/0", cyc, o_rsp_data, o_rsp_timeout, 32'hCAFE_0001 + RES_OFFSET); end
        i_rsp_ready = 1'b1;
        @(negedge clock);
        i_rsp_ready = 1'b0;
    endtask

    task automatic test_push_pop();
        int guard;
        clear_trackers();
        @(negedge clock);
        i_cmd_valid = 1'b1; i_cmd_data = 32'h0000_00A0;
        @(negedge clock); observe();
        i_cmd_data = 32'h0000_00B1;
        n_checks++; if (o_fifo_count !== 3'd1 || o_run_req !== 1'b0) begin n_fail++; $display("FAIL pp_empty_push: count %0d req %b exp 1/0", o_fifo_count, o_run_req); end
        @(negedge clock); observe();
        i_cmd_valid = 1'b0;
        n_checks++; if (o_fifo_count !== 3'd1 || o_run_req !== 1'b1 || o_run_input_a_0 !== 32'h0000_00A0) begin n_fail++; $display("FAIL pp_coincide: count %0d req %b input %h exp 1/1/000000a0", o_fifo_count, o_run_req, o_run_input_a_0); end
        i_rsp_ready = 1'b1;
        guard = 0;
        while (n_rsp < 2 && guard < 100) begin
            @(negedge clock); guard++; observe();
        end
        @(negedge clock);
        i_rsp_ready = 1'b0;
        n_checks++; if (n_iss !== 2 || issued[1] !== 32'h0000_00B1) begin n_fail++; $display("FAIL pp_second_issue: issued %0d data %h exp 2/000000b1", n_iss, issued[1]); end
        n_checks++; if (rsp_seen[0] !== 32'h0000_00A0 + RES_OFFSET || rsp_seen[1] !== 32'h0000_00B1 + RES_OFFSET) begin n_fail++; $display("FAIL pp_rsp: got %h %h exp %h %h", rsp_seen[0], rsp_seen[1], 32'h0000_00A0 + RES_OFFSET, 32'h0000_00B1 + RES_OFFSET); end
    endtask

    task automatic test_ce_gating();
        @(negedge clock);
        i_cmd_valid = 1'b1; i_cmd_data = 32'h0BAD_F00D;
        @(negedge clock);
        i_cmd_valid = 1'b0;
        @(negedge clock);
        n_checks++; if (o_run_req !== 1'b1) begin n_fail++; $display("FAIL ce_req: got %b exp 1", o_run_req); end
        repeat (7) @(negedge clock);
        ce = 1'b0;
        i_cmd_valid = 1'b1; i_cmd_data = 32'h7777_7777;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            n_checks++; if (o_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL ce_no_capture[%0d]: got %b exp 0", k, o_rsp_valid); end
        end
        n_checks++; if (o_fifo_count !== 3'd0) begin n_fail++; $display("FAIL ce_no_push: got %0d exp 0", o_fifo_count); end
        ce = 1'b1;
        i_cmd_valid = 1'b0;
        @(negedge clock);
        n_checks++; if (o_rsp_valid !== 1'b1 || o_rsp_data !== 32'h0BAD_F00D + RES_OFFSET || o_rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL ce_capture: valid %b data %h to %b exp 1/%h/0", o_rsp_valid, o_rsp_data, o_rsp_timeout, 32'h0BAD_F00D + RES_OFFSET); end
        i_rsp_ready = 1'b1;
        @(negedge clock);
        i_rsp_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        int cyc;
        @(negedge clock);
        i_cmd_valid = 1'b1; i_cmd_data = 32'h5555_AAAA;
        @(negedge clock);
        i_cmd_data = 32'h0F0F_0F0F;
        @(negedge clock);
        i_cmd_valid = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++; if (o_fifo_count !== 3'd1 || o_run_input_a_0 !== 32'h5555_AAAA) begin n_fail++; $display("FAIL ar_pre: count %0d input %h exp 1/5555aaaa", o_fifo_count, o_run_input_a_0); end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++; if (o_fifo_count !== 3'd0 || o_run_req !== 1'b0 || o_run_input_a_0 !== 32'h0) begin n_fail++; $display("FAIL ar_clear: count %0d req %b input %h exp 0/0/0", o_fifo_count, o_run_req, o_run_input_a_0); end
        n_checks++; if (o_rsp_valid !== 1'b0 || o_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ar_clear_rsp: valid %b ready %b exp 0/1", o_rsp_valid, o_cmd_ready); end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        i_cmd_valid = 1'b1; i_cmd_data = 32'h3F80_0000;
        @(negedge clock);
        i_cmd_valid = 1'b0;
        @(negedge clock);
        n_checks++; if (o_run_req !== 1'b1 || o_run_input_a_0 !== 32'h3F80_0000) begin n_fail++; $display("FAIL ar_fresh_req: req %b input %h exp 1/3f800000", o_run_req, o_run_input_a_0); end
        cyc = 0;
        while (!o_rsp_valid && cyc < 40) begin
            @(negedge clock); cyc++;
        end
        n_checks++; if (cyc !== 9 || o_rsp_data !== 32'h4013_3333 || o_rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL ar_fresh_rsp: lat %0d data %h to %b exp 9/40133333/0", cyc, o_rsp_data, o_rsp_timeout); end
        i_rsp_ready = 1'b1;
        @(negedge clock);
        i_rsp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset_n     = 1'b0;
        ce          = 1'b1;
        i_cmd_valid = 1'b0;
        i_cmd_data  = 32'h0;
        i_rsp_ready = 1'b0;
        callee_en   = 1'b1;
        clear_trackers();
        test_reset();
        test_single_call();
        test_back_to_back();
        test_timeout();
        test_push_pop();
        test_ce_gating();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
